plb_dac_stream: RTL and testbench

Parametrised multi-channel DAC output engine, the successor to the single-channel PLB DAC peripheral. It buffers whole sample frames (one sample per channel) from the bus-side register logic in a frame FIFO, paces them out with a programmable rate divider, and drives the DAC pins in either parallel (one lane per channel) or interleaved (all channels time-multiplexed on lane 0) mode. It sits between the PLB slave register/IPIF logic and the DAC pad ring, and reports underflow and overflow.

---
 rtl/plb_dac_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_plb_dac_stream.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plb_dac_stream.sv
// Multi-channel DAC output engine: frame FIFO, programmable rate divider and
// parallel or interleaved lane driver with sticky underflow/overflow flags.
module plb_dac_stream #(
    parameter int DAC_WIDTH  = 10,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              SPLB_Clk,
    input  logic                              SPLB_Rst_n,
    input  logic                              Samp_Wr,
    input  logic [NUM_CH*DAC_WIDTH-1:0]       Samp_Data,
    output logic                              Samp_Full,
    output logic [$clog2(FIFO_DEPTH):0]       Fifo_Level,
    input  logic                              Ctrl_En,
    input  logic                              Ctrl_Mode,
    input  logic [DIV_WIDTH-1:0]              Ctrl_Div,
    input  logic                              Clr_Flags,
    output logic                              Underflow,
    output logic                              Overflow,
    output logic [NUM_CH*DAC_WIDTH-1:0]       S_Data,
    output logic [$clog2(NUM_CH)-1:0]         S_Sel,
    output logic                              S_DCLK,
    output logic                              S_PWRDN
);

    localparam int SEL_W   = $clog2(NUM_CH);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int FRAME_W = NUM_CH * DAC_WIDTH;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------- frame FIFO ----------------
    logic [FRAME_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr, r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_full;

    logic               w_empty;
    logic               w_wr_acc;
    logic               w_pop;
    logic [FRAME_W-1:0] w_head;
    logic [LVL_W-1:0]   w_level_nxt;

    assign w_empty  = (r_level == '0);
    assign w_wr_acc = Samp_Wr & ~r_full;
    assign w_head   = r_mem[r_rptr];

    always_ff @(posedge SPLB_Clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= Samp_Data;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LVL);
        end
    end

    // ---------------- rate divider ----------------
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [DIV_WIDTH:0]   w_half;
    logic [DIV_WIDTH-1:0] w_lo_init;
    logic                 w_tick;

    assign w_div_eff = (Ctrl_Div == '0) ? DIV_WIDTH'(1) : Ctrl_Div;
    assign w_half    = ({1'b0, w_div_eff} + 1'b1) >> 1;
    assign w_lo_init = DIV_WIDTH'(w_half - 1'b1);
    assign w_tick    = Ctrl_En & (r_cnt == '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!Ctrl_En) begin
            w_cnt_nxt = '0;
        end else if (w_tick) begin
            w_cnt_nxt = w_div_eff;
        end else begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // ---------------- lane driver ----------------
    logic [FRAME_W-1:0]   r_data, w_data_nxt;
    logic [FRAME_W-1:0]   r_hold, w_hold_nxt;
    logic [SEL_W-1:0]     r_sel, w_sel_nxt;
    logic [SEL_W-1:0]     r_idx, w_idx_nxt;
    logic                 r_mode, w_mode_nxt;
    logic                 w_mode_eff;
    logic                 w_frame_start;
    logic                 w_upd;
    logic [FRAME_W-1:0]   w_src;
    logic [DAC_WIDTH-1:0] w_lane0;

    // A new frame is only ever fetched at channel index 0; mode follows the same rule.
    assign w_frame_start = (r_idx == '0);
    assign w_mode_eff    = w_frame_start ? Ctrl_Mode : r_mode;
    assign w_pop         = w_tick & w_frame_start & ~w_empty;
    assign w_src         = (w_frame_start && !w_empty) ? w_head : r_hold;

    always_comb begin
        w_lane0 = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_idx == SEL_W'(k)) begin
                w_lane0 = w_src[k*DAC_WIDTH +: DAC_WIDTH];
            end
        end
    end

    always_comb begin
        w_data_nxt = r_data;
        w_hold_nxt = r_hold;
        w_sel_nxt  = r_sel;
        w_idx_nxt  = r_idx;
        w_mode_nxt = r_mode;
        w_upd      = 1'b0;
        if (!Ctrl_En) begin
            w_idx_nxt = '0;
        end else if (w_tick) begin
            if (w_frame_start) begin
                w_mode_nxt = Ctrl_Mode;
            end
            if (!w_mode_eff) begin
                // Parallel underflow leaves the lanes and latch clock untouched.
                if (!w_empty) begin
                    w_data_nxt = w_head;
                    w_sel_nxt  = '0;
                    w_upd      = 1'b1;
                end
            end else begin
                if (w_frame_start && !w_empty) begin
                    w_hold_nxt = w_head;
                end
                w_data_nxt                = '0;
                w_data_nxt[DAC_WIDTH-1:0] = w_lane0;
                w_sel_nxt                 = r_idx;
                w_idx_nxt                 = (r_idx == LAST_CH) ? '0 : r_idx + 1'b1;
                w_upd                     = 1'b1;
            end
        end
    end

    // ---------------- latch clock ----------------
    logic                 r_dclk, w_dclk_nxt;
    logic [DIV_WIDTH-1:0] r_lo, w_lo_nxt;

    always_comb begin
        w_dclk_nxt = r_dclk;
        w_lo_nxt   = r_lo;
        if (!Ctrl_En) begin
            w_dclk_nxt = 1'b1;
            w_lo_nxt   = '0;
        end else if (w_upd) begin
            w_dclk_nxt = 1'b0;
            w_lo_nxt   = w_lo_init;
        end else if (r_lo != '0) begin
            w_lo_nxt = r_lo - 1'b1;
        end else begin
            w_dclk_nxt = 1'b1;
        end
    end

    // ---------------- status flags ----------------
    logic r_uf, r_ovf, r_pwrdn;
    logic w_uf_set, w_ovf_set;

    assign w_uf_set  = w_tick & w_frame_start & w_empty;
    assign w_ovf_set = Samp_Wr & r_full;

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_hold  <= '0;
            r_sel   <= '0;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_dclk  <= 1'b1;
            r_lo    <= '0;
            r_uf    <= 1'b0;
            r_ovf   <= 1'b0;
            r_pwrdn <= 1'b1;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_hold  <= w_hold_nxt;
            r_sel   <= w_sel_nxt;
            r_idx   <= w_idx_nxt;
            r_mode  <= w_mode_nxt;
            r_dclk  <= w_dclk_nxt;
            r_lo    <= w_lo_nxt;
            r_pwrdn <= ~Ctrl_En;
            if (w_uf_set)       r_uf <= 1'b1;
            else if (Clr_Flags) r_uf <= 1'b0;
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (Clr_Flags) r_ovf <= 1'b0;
        end
    end

    assign Samp_Full  = r_full;
    assign Fifo_Level = r_level;
    assign Underflow  = r_uf;
    assign Overflow   = r_ovf;
    assign S_Data     = r_data;
    assign S_Sel      = r_sel;
    assign S_DCLK     = r_dclk;
    assign S_PWRDN    = r_pwrdn;

endmodule

// File: tb/tb_plb_dac_stream.sv
// Directed bench for plb_dac_stream: DAC updates (each S_DCLK fall) are
// checked against an expected queue of {cycle, S_Sel, S_Data}.
module tb_plb_dac_stream;

    localparam int DW = 10;
    localparam int NC = 2;
    localparam int FD = 16;
    localparam int VW = 16;
    localparam int FW = NC * DW;
    localparam int EW = 16 + 1 + FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          samp_wr;
    logic [FW-1:0] samp_data;
    logic          samp_full;
    logic [4:0]    fifo_level;
    logic          ctrl_en;
    logic          ctrl_mode;
    logic [VW-1:0] ctrl_div;
    logic          clr_flags;
    logic          underflow;
    logic          overflow;
    logic [FW-1:0] s_data;
    logic [0:0]    s_sel;
    logic          s_dclk;
    logic          s_pwrdn;

    plb_dac_stream #(
        .DAC_WIDTH(DW), .NUM_CH(NC), .FIFO_DEPTH(FD), .DIV_WIDTH(VW)
    ) dut (
        .SPLB_Clk(clk), .SPLB_Rst_n(rst_n),
        .Samp_Wr(samp_wr), .Samp_Data(samp_data), .Samp_Full(samp_full),
        .Fifo_Level(fifo_level), .Ctrl_En(ctrl_en), .Ctrl_Mode(ctrl_mode),
        .Ctrl_Div(ctrl_div), .Clr_Flags(clr_flags), .Underflow(underflow),
        .Overflow(overflow), .S_Data(s_data), .S_Sel(s_sel),
        .S_DCLK(s_dclk), .S_PWRDN(s_pwrdn)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [FW-1:0] d);
        samp_wr   = 1'b1;
        samp_data = d;
        step();
        samp_wr   = 1'b0;
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    task automatic expect_upd(input int at, input logic sel, input logic [FW-1:0] d);
        exp_q.push_back({16'(at), sel, d});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic          prev_dclk = 1'b1;
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_act;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dclk = 1'b1;
        end else begin
            if (prev_dclk && !s_dclk) begin
                checks++;
                mon_act = {16'(cyc), s_sel, s_data};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL dac_update_unexpected: got cyc=%0d sel=%0h data=%0h, required no update",
                             cyc, s_sel, s_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        failures++;
                        $display("FAIL dac_update: got cyc=%0d sel=%0h data=%0h, required cyc=%0d sel=%0h data=%0h",
                                 mon_act[EW-1 -: 16], mon_act[FW], mon_act[FW-1:0],
                                 mon_exp[EW-1 -: 16], mon_exp[FW], mon_exp[FW-1:0]);
                    end
                end
            end
            prev_dclk = s_dclk;
        end
    end

    // ---------------- directed stimulus ----------------
    int base;

    initial begin
        rst_n     = 1'b0;
        samp_wr   = 1'b0;
        samp_data = '0;
        ctrl_en   = 1'b0;
        ctrl_mode = 1'b0;
        ctrl_div  = 16'd3;
        clr_flags = 1'b0;
        step();
        step();
        chk("rst_s_data", 32'(s_data), 32'h0);
        chk("rst_s_dclk", 32'(s_dclk), 32'h1);
        chk("rst_s_pwrdn", 32'(s_pwrdn), 32'h1);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_full", 32'(samp_full), 32'h0);
        rst_n = 1'b1;
        step();

        // Parallel, Ctrl_Div=3
        write_frame({10'h155, 10'h0AA});
        write_frame({10'h3FF, 10'h001});
        chk("par_level_two", 32'(fifo_level), 32'd2);
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h155, 10'h0AA});
        expect_upd(base + 5, 1'b0, {10'h3FF, 10'h001});
        for (int i = 1; i <= 9; i++) begin
            step();
            case (i)
                1: begin
                    chk("par_dclk_c1", 32'(s_dclk), 32'h0);
                    chk("par_level_c1", 32'(fifo_level), 32'd1);
                    chk("par_pwrdn_c1", 32'(s_pwrdn), 32'h0);
                end
                2: chk("par_dclk_c2", 32'(s_dclk), 32'h0);
                3: chk("par_dclk_c3", 32'(s_dclk), 32'h1);
                5: chk("par_level_c5", 32'(fifo_level), 32'd0);
                8: chk("par_uf_c8", 32'(underflow), 32'h0);
                9: begin
                    chk("par_uf_c9", 32'(underflow), 32'h1);
                    chk("par_hold_c9", 32'(s_data), 32'({10'h3FF, 10'h001}));
                    chk("par_dclk_c9", 32'(s_dclk), 32'h1);
                end
                default: ;
            endcase
        end
        ctrl_en = 1'b0;
        step();
        chk("dis_pwrdn", 32'(s_pwrdn), 32'h1);
        chk("dis_dclk", 32'(s_dclk), 32'h1);
        clear_flags();
        chk("clr_uf", 32'(underflow), 32'h0);

        // Interleaved, Ctrl_Div=1, underflow reuses the hold register
        ctrl_div  = 16'd1;
        ctrl_mode = 1'b1;
        write_frame({10'h200, 10'h100});
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h000, 10'h100});
        expect_upd(base + 3, 1'b1, {10'h000, 10'h200});
        expect_upd(base + 5, 1'b0, {10'h000, 10'h100});
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 4) chk("il_uf_c4", 32'(underflow), 32'h0);
            if (i == 5) chk("il_uf_c5", 32'(underflow), 32'h1);
        end
        ctrl_en = 1'b0;
        step();
        clear_flags();

        // Mode change mid-frame is deferred to the next frame start
        write_frame({10'h0C3, 10'h03C});
        write_frame({10'h2AB, 10'h155});
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h000, 10'h03C});
        expect_upd(base + 3, 1'b1, {10'h000, 10'h0C3});
        expect_upd(base + 5, 1'b0, {10'h2AB, 10'h155});
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) ctrl_mode = 1'b0;
        end
        chk("mode_level", 32'(fifo_level), 32'd0);
        chk("mode_uf", 32'(underflow), 32'h0);
        ctrl_en = 1'b0;
        step();

        // Disable mid interleaved frame abandons it without re-popping
        ctrl_mode = 1'b1;
        write_frame({10'h111, 10'h222});
        write_frame({10'h333, 10'h044});
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h000, 10'h222});
        step();
        ctrl_en = 1'b0;
        step();
        chk("abandon_level", 32'(fifo_level), 32'd1);
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h000, 10'h044});
        step();
        ctrl_en = 1'b0;
        step();
        chk("abandon_level_after", 32'(fifo_level), 32'd0);

        // Ctrl_Div 3 -> 7 mid-period
        ctrl_mode = 1'b0;
        ctrl_div  = 16'd3;
        write_frame({10'h011, 10'h022});
        write_frame({10'h033, 10'h044});
        write_frame({10'h055, 10'h066});
        ctrl_en = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, {10'h011, 10'h022});
        expect_upd(base + 5, 1'b0, {10'h033, 10'h044});
        expect_upd(base + 13, 1'b0, {10'h055, 10'h066});
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i == 2) ctrl_div = 16'd7;
            if (i == 8) chk("div7_dclk_low", 32'(s_dclk), 32'h0);
            if (i == 9) chk("div7_dclk_high", 32'(s_dclk), 32'h1);
            if (i == 12) chk("div7_level", 32'(fifo_level), 32'd1);
        end
        ctrl_en  = 1'b0;
        ctrl_div = 16'd3;
        step();
        clear_flags();

        // Fill, overflow, clear against simultaneous overflow
        for (int i = 0; i < FD; i++) begin
            write_frame(FW'(i * 37 + 5));
        end
        chk("fill_full", 32'(samp_full), 32'h1);
        chk("fill_level", 32'(fifo_level), 32'd16);
        write_frame(20'hABCDE);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_level", 32'(fifo_level), 32'd16);
        clr_flags = 1'b1;
        write_frame(20'hABCDE);
        clr_flags = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'h1);
        clear_flags();
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO: write and tick together
        samp_wr   = 1'b1;
        samp_data = 20'h12345;
        ctrl_en   = 1'b1;
        base = cyc;
        expect_upd(base + 1, 1'b0, 20'd5);
        step();
        samp_wr = 1'b0;
        ctrl_en = 1'b0;
        chk("fulltick_level", 32'(fifo_level), 32'd15);
        chk("fulltick_ovf", 32'(overflow), 32'h1);
        chk("fulltick_full", 32'(samp_full), 32'h0);
        step();

        // Asynchronous reset mid-cycle with data still queued
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'h0);
        chk("arst_s_data", 32'(s_data), 32'h0);
        chk("arst_s_sel", 32'(s_sel), 32'h0);
        chk("arst_dclk", 32'(s_dclk), 32'h1);
        chk("arst_pwrdn", 32'(s_pwrdn), 32'h1);
        step();
        rst_n = 1'b1;
        step();

        // Empty FIFO: write and tick together
        samp_wr   = 1'b1;
        samp_data = 20'h0F0F0;
        ctrl_en   = 1'b1;
        base = cyc;
        expect_upd(base + 5, 1'b0, 20'h0F0F0);
        step();
        samp_wr = 1'b0;
        chk("emptytick_uf", 32'(underflow), 32'h1);
        chk("emptytick_level", 32'(fifo_level), 32'd1);
        for (int i = 2; i <= 6; i++) begin
            step();
            if (i == 5) chk("emptytick_level_pop", 32'(fifo_level), 32'd0);
        end
        ctrl_en = 1'b0;
        step();
        step();
        step();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
